// File: rtl/reg_bank_serializer.sv
// reg_bank_serializer: snapshots an eight-word register bank (r0..r7) on an
// accepted start, then streams the words out one per beat over valid/ready.
// REVERSE selects the emission order (0: r0..r7, 1: r7..r0).
// Optional feature macro: REG_BANK_SERIALIZER_CHECKSUM_EN appends a ninth
// beat carrying the XOR of the snapshot words, with out_idx = 8.
module reg_bank_serializer #(
  parameter int DATA_W  = 32,
  parameter int REVERSE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] r0,
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] r2,
  input  logic [DATA_W-1:0] r3,
  input  logic [DATA_W-1:0] r4,
  input  logic [DATA_W-1:0] r5,
  input  logic [DATA_W-1:0] r6,
  input  logic [DATA_W-1:0] r7,
  input  logic              start,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND
`ifdef REG_BANK_SERIALIZER_CHECKSUM_EN
    ,CSUM
`endif
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_buf [8];
  logic [2:0]        r_cnt;
  logic [DATA_W-1:0] r_data;
  logic [3:0]        r_idx;
  logic              r_done;

  logic [DATA_W-1:0] w_in [8];
  logic              w_load;
  logic [2:0]        w_cnt_nxt;
  logic [2:0]        w_cnt_inc;
  logic [DATA_W-1:0] w_data_nxt;
  logic [3:0]        w_idx_nxt;
  logic              w_done_nxt;

  // Map beat number to source index according to the emission order.
  function automatic logic [2:0] f_sel(input logic [2:0] k);
    return (REVERSE != 0) ? (3'd7 - k) : k;
  endfunction

  assign w_in[0] = r0;
  assign w_in[1] = r1;
  assign w_in[2] = r2;
  assign w_in[3] = r3;
  assign w_in[4] = r4;
  assign w_in[5] = r5;
  assign w_in[6] = r6;
  assign w_in[7] = r7;

  assign w_cnt_inc = r_cnt + 3'd1;

`ifdef REG_BANK_SERIALIZER_CHECKSUM_EN
  logic [DATA_W-1:0] w_csum;

  // XOR of the snapshot words, immune to input changes after start.
  always_comb begin
    w_csum = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_csum = w_csum ^ r_buf[i];
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus the next beat's word/index; the beat after the current one
  // is loaded into the output registers on the transferring edge, so output
  // is stable during stalls and there are no bubbles with ready held high.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_data_nxt  = w_in[f_sel(3'd0)];
          w_idx_nxt   = {1'b0, f_sel(3'd0)};
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (r_cnt != 3'd7) begin
            w_cnt_nxt  = w_cnt_inc;
            w_data_nxt = r_buf[f_sel(w_cnt_inc)];
            w_idx_nxt  = {1'b0, f_sel(w_cnt_inc)};
          end else begin
`ifdef REG_BANK_SERIALIZER_CHECKSUM_EN
            w_data_nxt  = w_csum;
            w_idx_nxt   = 4'd8;
            w_state_nxt = CSUM;
`else
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
`endif
          end
        end
      end
`ifdef REG_BANK_SERIALIZER_CHECKSUM_EN
      CSUM: begin
        if (out_ready) begin
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // Snapshot buffer, beat counter, output word/index and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) r_buf[i] <= '0;
      r_cnt  <= '0;
      r_data <= '0;
      r_idx  <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_load) begin
        for (int unsigned i = 0; i < 8; i++) r_buf[i] <= w_in[i];
      end
      r_cnt  <= w_cnt_nxt;
      r_data <= w_data_nxt;
      r_idx  <= w_idx_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign out_valid = (r_state != IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_reg_bank_serializer.sv
// Directed bench for reg_bank_serializer: forward and reverse order,
// backpressure, snapshot/ignored start, async reset and back-to-back starts.
// Build with +define+REG_BANK_SERIALIZER_CHECKSUM_EN to expect the 9th beat.
module tb_reg_bank_serializer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] r [8];
  logic          start;
  logic          out_ready;

  logic [DW-1:0] f_data, v_data;
  logic [3:0]    f_idx, v_idx;
  logic          f_valid, v_valid, f_busy, v_busy, f_done, v_done;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] exp_w [8];
  localparam logic [DW-1:0] CSUM_EXP = 32'd66;

  always #5 clk = ~clk;

  reg_bank_serializer #(.DATA_W(DW), .REVERSE(0)) u_fwd (
    .clk(clk), .reset(reset),
    .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]),
    .r4(r[4]), .r5(r[5]), .r6(r[6]), .r7(r[7]),
    .start(start), .out_data(f_data), .out_idx(f_idx), .out_valid(f_valid),
    .out_ready(out_ready), .busy(f_busy), .done(f_done)
  );

  reg_bank_serializer #(.DATA_W(DW), .REVERSE(1)) u_rev (
    .clk(clk), .reset(reset),
    .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]),
    .r4(r[4]), .r5(r[5]), .r6(r[6]), .r7(r[7]),
    .start(start), .out_data(v_data), .out_idx(v_idx), .out_valid(v_valid),
    .out_ready(out_ready), .busy(v_busy), .done(v_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called with the first beat visible; returns in the done cycle.
  // stall_at/stall_n: hold ready low for stall_n cycles at that beat.
  // poke_at: at that beat, change r3 to 99 and pulse start.
  task automatic stream(input int stall_at, input int stall_n, input int poke_at, input bit chk_rev);
    for (int b = 0; b < 8; b++) begin
      check_eq("beat_valid", f_valid, 1'b1);
      check_eq("beat_busy", f_busy, 1'b1);
      check_eq("beat_done", f_done, 1'b0);
      check_eq("beat_data", f_data, exp_w[b]);
      check_eq("beat_idx", f_idx, b);
      if (chk_rev) begin
        check_eq("rev_data", v_data, exp_w[7-b]);
        check_eq("rev_idx", v_idx, 7 - b);
      end
      if (b == poke_at) begin
        r[3]  = 32'd99;
        start = 1'b1;
      end
      if (b == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          start = 1'b0;
          check_eq("stall_valid", f_valid, 1'b1);
          check_eq("stall_data", f_data, exp_w[b]);
          check_eq("stall_idx", f_idx, b);
        end
        out_ready = 1'b1;
      end
      tick();
      start = 1'b0;
    end
`ifdef REG_BANK_SERIALIZER_CHECKSUM_EN
    check_eq("csum_valid", f_valid, 1'b1);
    check_eq("csum_data", f_data, CSUM_EXP);
    check_eq("csum_idx", f_idx, 4'd8);
    check_eq("csum_done", f_done, 1'b0);
    if (chk_rev) begin
      check_eq("rev_csum_data", v_data, CSUM_EXP);
      check_eq("rev_csum_idx", v_idx, 4'd8);
    end
    tick();
`endif
    check_eq("end_done", f_done, 1'b1);
    check_eq("end_valid", f_valid, 1'b0);
    check_eq("end_busy", f_busy, 1'b0);
    if (chk_rev) check_eq("rev_end_done", v_done, 1'b1);
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    check_eq({tag, "_valid"}, f_valid, 1'b0);
    check_eq({tag, "_busy"}, f_busy, 1'b0);
    check_eq({tag, "_done"}, f_done, 1'b0);
  endtask

  initial begin
    exp_w = '{32'd15, 32'd7, 32'd18, 32'd55, 32'd42, 32'd17, 32'd5, 32'd81};
    for (int i = 0; i < 8; i++) r[i] = exp_w[i];
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    idle_check("rst");
    check_eq("rst_data", f_data, 0);
    check_eq("rst_idx", f_idx, 0);
    reset = 1'b0;
    tick();

    // Basic transfer, both orders
    kick();
    stream(-1, 0, -1, 1'b1);
    tick();
    idle_check("basic_after");
`ifdef REG_BANK_SERIALIZER_CHECKSUM_EN
    check_eq("idle_hold_data", f_data, CSUM_EXP);
`else
    check_eq("idle_hold_data", f_data, 32'd81);
`endif

    // Backpressure at beat 2 for 3 cycles
    tick();
    kick();
    stream(2, 3, -1, 1'b0);
    tick();
    idle_check("bp_after");

    // Snapshot: r3 changes and start pulses during beat 1
    kick();
    stream(-1, 0, 1, 1'b0);
    tick();
    idle_check("snap_after");
    r[3] = 32'd55;

    // Asynchronous reset at beat 4
    kick();
    for (int b = 0; b < 4; b++) tick();
    check_eq("pre_rst_data", f_data, 32'd42);
    check_eq("pre_rst_idx", f_idx, 4);
    #1;
    reset = 1'b1;
    #1;
    check_eq("arst_valid", f_valid, 1'b0);
    check_eq("arst_busy", f_busy, 1'b0);
    check_eq("arst_data", f_data, 0);
    check_eq("arst_idx", f_idx, 0);
    check_eq("arst_done", f_done, 1'b0);
    tick();
    check_eq("arst_hold_done", f_done, 1'b0);
    reset = 1'b0;
    tick();
    idle_check("arst_after");

    // Back-to-back: start in the done cycle
    kick();
    stream(-1, 0, -1, 1'b0);
    kick();
    stream(-1, 0, -1, 1'b1);
    tick();
    idle_check("b2b_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
